// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for a rate-1/2 Viterbi decoder: feeds symbol pairs to BMC/ACS, runs full-frame
// traceback into a bit buffer, then streams the decoded (non-tail) bits out with valid/ready.
module viterbi_frame_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned TAIL  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   frame_len,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic [1:0]    sym_data,
  output logic [1:0]    rx_pair,
  output logic          sm_init,
  output logic          acs_en,
  output logic          surv_wr_en,
  output logic [AW-1:0] surv_wr_addr,
  output logic          tb_en,
  output logic [AW-1:0] surv_rd_addr,
  input  logic          tb_bit,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic          dec_bit,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] DepthL = DEPTH[AW:0];
  localparam logic [AW:0] TailL  = TAIL[AW:0];

  typedef enum logic [2:0] {StIdle, StAcs, StTb, StDrain, StOut} state_e;

  state_e           state_q, state_d;
  logic [AW:0]      len_q, len_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      out_q, out_d;
  logic [1:0]       rx_pair_q, rx_pair_d;
  logic             acs_en_q, acs_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic             sm_init_q, sm_init_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tb_dly_q, tb_dly_d;
  logic [AW-1:0]    tb_addr_q, tb_addr_d;
  logic [DEPTH-1:0] buf_q, buf_d;

  logic [AW:0]      len_m1;
  logic [AW:0]      last_idx;
  logic             sym_hs;

  assign len_m1   = len_q - 1'b1;
  assign last_idx = len_q - TailL - 1'b1;

  assign sym_ready    = (state_q == StAcs) && (cnt_q < len_q);
  assign sym_hs       = sym_ready && sym_valid;
  assign tb_en        = (state_q == StTb);
  assign surv_rd_addr = rd_q;
  assign dec_valid    = (state_q == StOut);
  assign dec_bit      = dec_valid & buf_q[out_q[AW-1:0]];
  assign busy         = (state_q != StIdle);
  assign rx_pair      = rx_pair_q;
  assign sm_init      = sm_init_q;
  assign acs_en       = acs_en_q;
  assign surv_wr_en   = acs_en_q;
  assign surv_wr_addr = wr_addr_q;
  assign done         = done_q;
  assign err          = err_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    out_d     = out_q;
    rx_pair_d = rx_pair_q;
    wr_addr_d = wr_addr_q;
    acs_en_d  = 1'b0;
    sm_init_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    // Traceback bit arrives one cycle after its read address; capture against the delayed address.
    tb_dly_d  = tb_en;
    tb_addr_d = rd_q;
    buf_d     = buf_q;
    if (tb_dly_q) begin
      buf_d[tb_addr_q] = tb_bit;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((frame_len > TailL) && (frame_len <= DepthL)) begin
            len_d     = frame_len;
            cnt_d     = '0;
            out_d     = '0;
            sm_init_d = 1'b1;
            state_d   = StAcs;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAcs: begin
        if (sym_hs) begin
          rx_pair_d = sym_data;
          acs_en_d  = 1'b1;
          wr_addr_d = cnt_q[AW-1:0];
          cnt_d     = cnt_q + 1'b1;
        end
        // Leave only once the last survivor write has actually been issued.
        if ((cnt_q == len_q) && acs_en_q) begin
          rd_d    = len_m1[AW-1:0];
          state_d = StTb;
        end
      end
      StTb: begin
        if (rd_q == '0) begin
          state_d = StDrain;
        end else begin
          rd_d = rd_q - 1'b1;
        end
      end
      StDrain: begin
        state_d = StOut;
      end
      StOut: begin
        if (dec_ready) begin
          if (out_q == last_idx) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            out_d = out_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      out_q     <= '0;
      rx_pair_q <= 2'b00;
      acs_en_q  <= 1'b0;
      wr_addr_q <= '0;
      sm_init_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tb_dly_q  <= 1'b0;
      tb_addr_q <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      out_q     <= out_d;
      rx_pair_q <= rx_pair_d;
      acs_en_q  <= acs_en_d;
      wr_addr_q <= wr_addr_d;
      sm_init_q <= sm_init_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tb_dly_q  <= tb_dly_d;
      tb_addr_q <= tb_addr_d;
      buf_q     <= buf_d;
    end
  end

endmodule
